sha256_k_sequencer: RTL and testbench

Registered, parametrised SHA-256 round-constant sequencer that replaces the purely combinational K lookup in the hash datapath. On `start` it steps through K[0]..K[63], presenting `UNROLL` consecutive constants per beat under a valid/advance handshake, so unrolled compression cores (1, 2, 4 or 8 rounds per cycle) can consume constants without their own round counter. It sits between the core controller and the compression-round logic.

---
 rtl/sha256_k_sequencer_if.sv | 25 ++
 rtl/sha256_k_sequencer.sv | 110 +++++++++++
 tb/tb_sha256_k_sequencer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_k_sequencer_if.sv
// Handshake bundle between the core controller / compression rounds and the K sequencer.
// Controller drives i_*, sequencer drives o_*; o_k_out carries UNROLL constants, K[round] in the low word.
interface sha256_k_sequencer_if #(
  parameter int UNROLL = 1
);
  logic                    i_start;
  logic                    i_abort;
  logic                    i_advance;
  logic                    o_k_valid;
  logic [32*UNROLL-1:0]    o_k_out;
  logic [5:0]              o_round;
  logic                    o_last;
  logic                    o_busy;
  logic                    o_done;

  modport master (
    output i_start, i_abort, i_advance,
    input  o_k_valid, o_k_out, o_round, o_last, o_busy, o_done
  );

  modport slave (
    input  i_start, i_abort, i_advance,
    output o_k_valid, o_k_out, o_round, o_last, o_busy, o_done
  );
endinterface

// File: rtl/sha256_k_sequencer.sv
// SHA-256 round-constant sequencer: UNROLL constants per beat, first beat one cycle after start.
// Beat held stable until i_advance; a start on the final accept restarts with no bubble.
module sha256_k_sequencer #(
  parameter int UNROLL = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sha256_k_sequencer_if.slave  bus
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
    $error("sha256_k_sequencer: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [5:0] LAST_ROUND = 6'(64 - UNROLL);
  localparam logic [5:0] STEP       = 6'(UNROLL);

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic [5:0]           r_round, w_round_nxt;
  logic [32*UNROLL-1:0] r_k_out, w_k_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_load;
  logic                 w_accept;
  logic                 w_last;

  assign w_last   = (r_state == S_RUN) && (r_round == LAST_ROUND);
  assign w_accept = (r_state == S_RUN) && bus.i_advance;

  always_comb begin
    w_state_nxt = r_state;
    w_round_nxt = r_round;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    if (bus.i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.i_start) begin
            w_state_nxt = S_RUN;
            w_round_nxt = '0;
            w_load      = 1'b1;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_last) begin
              w_done_nxt = 1'b1;
              if (bus.i_start) begin
                w_round_nxt = '0;
                w_load      = 1'b1;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end else begin
              w_round_nxt = r_round + STEP;
              w_load      = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ROM is addressed by the round being loaded so k_out is ready with the beat.
  always_comb begin
    w_k_nxt = '0;
    for (int j = 0; j < UNROLL; j++) begin
      w_k_nxt[32*j +: 32] = K_ROM[w_round_nxt + 6'(j)];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_round <= '0;
      r_k_out <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_round <= w_round_nxt;
        r_k_out <= w_k_nxt;
      end
    end
  end

  assign bus.o_k_valid = (r_state == S_RUN);
  assign bus.o_busy    = (r_state == S_RUN);
  assign bus.o_k_out   = r_k_out;
  assign bus.o_round   = r_round;
  assign bus.o_last    = w_last;
  assign bus.o_done    = r_done;

endmodule

// File: tb/tb_sha256_k_sequencer.sv
// Scoreboard bench for sha256_k_sequencer at UNROLL = 1, 2 and 4.
// Stimulus queues expected beats; a negedge monitor compares every presented beat and done pulse.
module tb_sha256_k_sequencer;

  typedef struct {
    logic [5:0]   rnd;
    logic [255:0] k;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Index 0: UNROLL=1, 1: UNROLL=2, 2: UNROLL=4
  logic         start   [3];
  logic         abort   [3];
  logic         advance [3];
  logic         vld     [3];
  logic         last    [3];
  logic         busy    [3];
  logic         done    [3];
  logic [5:0]   rnd     [3];
  logic [255:0] kout    [3];

  beat_t q [3][$];
  logic  pend [3];

  int n_checks = 0;
  int n_errors = 0;

  sha256_k_sequencer_if #(.UNROLL(1)) if1 ();
  sha256_k_sequencer_if #(.UNROLL(2)) if2 ();
  sha256_k_sequencer_if #(.UNROLL(4)) if4 ();

  sha256_k_sequencer #(.UNROLL(1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(if1.slave));
  sha256_k_sequencer #(.UNROLL(2)) u_dut2 (.i_clk(clk), .i_rst(rst), .bus(if2.slave));
  sha256_k_sequencer #(.UNROLL(4)) u_dut4 (.i_clk(clk), .i_rst(rst), .bus(if4.slave));

  assign if1.i_start = start[0];  assign if1.i_abort = abort[0];  assign if1.i_advance = advance[0];
  assign if2.i_start = start[1];  assign if2.i_abort = abort[1];  assign if2.i_advance = advance[1];
  assign if4.i_start = start[2];  assign if4.i_abort = abort[2];  assign if4.i_advance = advance[2];

  assign vld[0] = if1.o_k_valid;  assign vld[1] = if2.o_k_valid;  assign vld[2] = if4.o_k_valid;
  assign last[0] = if1.o_last;    assign last[1] = if2.o_last;    assign last[2] = if4.o_last;
  assign busy[0] = if1.o_busy;    assign busy[1] = if2.o_busy;    assign busy[2] = if4.o_busy;
  assign done[0] = if1.o_done;    assign done[1] = if2.o_done;    assign done[2] = if4.o_done;
  assign rnd[0]  = if1.o_round;   assign rnd[1]  = if2.o_round;   assign rnd[2]  = if4.o_round;
  assign kout[0] = {224'h0, if1.o_k_out};
  assign kout[1] = {192'h0, if2.o_k_out};
  assign kout[2] = {128'h0, if4.o_k_out};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unroll_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  task automatic push_seq(input int d);
    beat_t b;
    int    u;
    u = unroll_of(d);
    for (int r = 0; r < 64; r += u) begin
      b.rnd  = 6'(r);
      b.k    = '0;
      for (int j = 0; j < u; j++) b.k[32*j +: 32] = K_TB[r+j];
      b.last = (r == 64 - u);
      q[d].push_back(b);
    end
  endtask

  // Stimulus always sits 1 time unit after a rising edge.
  task automatic start_seq(input int d);
    push_seq(d);
    start[d]   = 1'b1;
    advance[d] = 1'b1;
    @(posedge clk); #1;
    start[d]   = 1'b0;
  endtask

  task automatic wait_done(input int d, input string tag);
    int n;
    n = 0;
    while ((q[d].size() != 0 || vld[d]) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("%s_timeout", tag), (n < 2000), 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk($sformatf("%s_vld%0d", tag, d),   vld[d],  0);
    chk($sformatf("%s_busy%0d", tag, d),  busy[d], 0);
    chk($sformatf("%s_done%0d", tag, d),  done[d], 0);
    chk($sformatf("%s_last%0d", tag, d),  last[d], 0);
    chk($sformatf("%s_round%0d", tag, d), rnd[d],  0);
    chk($sformatf("%s_kout%0d", tag, d),  kout[d], 0);
  endtask

  // Monitor: the head of each queue must be presented while valid, popped on accept.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        logic nxt_pend;
        nxt_pend = 1'b0;
        chk($sformatf("done_u%0d", unroll_of(d)), done[d], pend[d]);
        if (vld[d]) begin
          chk($sformatf("busy_u%0d", unroll_of(d)), busy[d], 1);
          if (q[d].size() == 0) begin
            chk($sformatf("unexpected_beat_u%0d", unroll_of(d)), {250'h0, rnd[d]}, 256'h100);
          end else begin
            chk($sformatf("round_u%0d", unroll_of(d)), rnd[d],  q[d][0].rnd);
            chk($sformatf("kout_u%0d_r%0d", unroll_of(d), q[d][0].rnd), kout[d], q[d][0].k);
            chk($sformatf("last_u%0d_r%0d", unroll_of(d), q[d][0].rnd), last[d], q[d][0].last);
            if (advance[d]) begin
              nxt_pend = q[d][0].last;
              void'(q[d].pop_front());
            end
          end
        end else begin
          chk($sformatf("idle_busy_u%0d", unroll_of(d)), busy[d], 0);
          chk($sformatf("idle_last_u%0d", unroll_of(d)), last[d], 0);
        end
        pend[d] = nxt_pend;
      end
    end
  end

  initial begin
    int n;
    for (int d = 0; d < 3; d++) begin
      start[d] = 1'b0; abort[d] = 1'b0; advance[d] = 1'b0; pend[d] = 1'b0;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk_zero(d, "reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // UNROLL=1 full run with advance held high
    start_seq(0);
    chk("u1_first_kout", kout[0], 256'h428a2f98);
    wait_done(0, "u1_run");

    // UNROLL=4 full run
    start_seq(2);
    chk("u4_first_kout", kout[2], 256'he9b5dba5_b5c0fbcf_71374491_428a2f98);
    wait_done(2, "u4_run");

    // UNROLL=2 with random stalls
    start_seq(1);
    n = 0;
    while ((q[1].size() != 0 || vld[1]) && n < 2000) begin
      advance[1] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    chk("u2_stall_timeout", (n < 2000), 1);
    advance[1] = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: start with the final accept
    push_seq(0);
    start_seq(0);
    n = 0;
    while (!(vld[0] && rnd[0] == 6'd63) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_reach_last", (n < 200), 1);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    chk("b2b_vld",   vld[0],  1);
    chk("b2b_round", rnd[0],  0);
    chk("b2b_done",  done[0], 1);
    wait_done(0, "b2b");

    // Abort at round 20 together with start and advance
    start_seq(0);
    n = 0;
    while (!(vld[0] && rnd[0] == 6'd20) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach_20", (n < 200), 1);
    abort[0] = 1'b1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    start[0] = 1'b0;
    q[0].delete();
    chk("abort_vld",  vld[0],  0);
    chk("abort_busy", busy[0], 0);
    chk("abort_done", done[0], 0);
    @(posedge clk); #1;
    chk("abort_stay_idle", vld[0], 0);
    chk("abort_no_done",   done[0], 0);
    start_seq(0);
    chk("restart_round", rnd[0], 0);
    wait_done(0, "restart");

    // Asynchronous reset between edges mid-run
    start_seq(1);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_zero(1, "async_rst");
    q[1].delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_idle%0d", i), vld[1], 0);
    end
    start_seq(1);
    wait_done(1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
